// File: rtl/fft_pkg.sv
// Shared constants and types for the in-place radix-2 DIT FFT datapath.
package fft_pkg;

    localparam int FFT_LOG2N    = 9;
    localparam int FFT_N        = 1 << FFT_LOG2N;
    localparam int FFT_WR_DELAY = 6;

    typedef logic [FFT_LOG2N-1:0] addr_t;
    typedef logic [FFT_LOG2N-2:0] tw_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/fft_wr_delay_line.sv
// Write-back address pipeline: carries {valid, addr, is_b} from an operand
// read to the cycle its butterfly result is written back, DEPTH cycles later.
module fft_wr_delay_line #(
    parameter int DEPTH = 6,
    parameter int AW    = 9
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_vld,
    input  logic [AW-1:0] i_addr,
    input  logic          i_is_b,
    output logic          o_vld,
    output logic [AW-1:0] o_addr,
    output logic          o_is_b,
    output logic          o_empty
);

    logic [DEPTH-1:0]         vld_pipe;
    logic [DEPTH-1:0][AW-1:0] addr_pipe;
    logic [DEPTH-1:0]         isb_pipe;

    // Shift one slot per cycle; slot 0 captures the read issued this cycle.
    // Invalid slots carry zeros so the write outputs are clean when idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            isb_pipe  <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[DEPTH-2:0], i_vld};
            addr_pipe <= {addr_pipe[DEPTH-2:0], i_addr & {AW{i_vld}}};
            isb_pipe  <= {isb_pipe[DEPTH-2:0], i_vld & i_is_b};
        end
    end

    assign o_vld   = vld_pipe[DEPTH-1];
    assign o_addr  = addr_pipe[DEPTH-1];
    assign o_is_b  = isb_pipe[DEPTH-1];
    // Nothing is queued behind the output slot: whatever is leaving this
    // cycle (if anything) is the last entry in flight.
    assign o_empty = ~|vld_pipe[DEPTH-2:0];

endmodule

// File: rtl/fft_stage_seq.sv
// Stage sequencer for the in-place radix-2 DIT FFT. Walks every stage,
// issuing A then B operand reads with the twiddle index, delays each read
// address to its write-back slot, and drains the write pipeline between
// stages so stage s+1 never reads a location stage s has yet to write.
module fft_stage_seq
    import fft_pkg::*;
#(
    parameter int LOG2N    = FFT_LOG2N,
    parameter int WR_DELAY = FFT_WR_DELAY
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [3:0]       o_stage,
    output logic             o_rd_en,
    output logic [LOG2N-1:0] o_rd_addr,
    output logic             o_rd_is_b,
    output logic [LOG2N-2:0] o_tw_idx,
    output logic             o_wr_en,
    output logic [LOG2N-1:0] o_wr_addr,
    output logic             o_wr_is_b
);

    localparam int            KW     = LOG2N - 1;
    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [3:0]    S_LAST = 4'(LOG2N - 1);

    seq_state_t       state, state_nx;
    logic [KW-1:0]    k;
    logic [3:0]       s;
    logic             phase;
    logic             pipe_empty;
    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] addr_a;
    logic [KW-1:0]    pos_mask;
    logic [3:0]       tw_sh;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and the state-decoded status/read-enable outputs.
    always_comb begin
        state_nx = state;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_rd_en  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) state_nx = READ;
            end
            READ: begin
                o_busy  = 1'b1;
                o_rd_en = 1'b1;
                if (phase && k == K_LAST) state_nx = DRAIN;
            end
            DRAIN: begin
                o_busy = 1'b1;
                // pipe_empty marks the cycle the stage's final write goes out.
                if (pipe_empty) state_nx = (s == S_LAST) ? DONE : READ;
            end
            DONE: begin
                o_done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Butterfly counter, A/B phase and stage index. k wraps naturally at the
    // end of a stage; s stops at the last stage so DONE reports it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            k     <= '0;
            s     <= '0;
            phase <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        k     <= '0;
                        s     <= '0;
                        phase <= 1'b0;
                    end
                end
                READ: begin
                    phase <= ~phase;
                    if (phase) k <= k + 1'b1;
                end
                DRAIN: begin
                    if (pipe_empty && s != S_LAST) s <= s + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Operand address and twiddle index: the low s bits of k select the
    // position inside a group, the rest select the group of 2*half entries.
    always_comb begin
        k_ext     = LOG2N'(k);
        half      = LOG2N'(1) << s;
        pos_mask  = KW'(half - LOG2N'(1));
        tw_sh     = S_LAST - s;
        addr_a    = ((k_ext >> s) << (s + 4'd1)) | (k_ext & (half - LOG2N'(1)));
        o_rd_addr = '0;
        o_rd_is_b = 1'b0;
        o_tw_idx  = '0;
        if (o_rd_en) begin
            o_rd_addr = phase ? addr_a + half : addr_a;
            o_rd_is_b = phase;
            o_tw_idx  = (k & pos_mask) << tw_sh;
        end
    end

    assign o_stage = s;

    fft_wr_delay_line #(
        .DEPTH (WR_DELAY),
        .AW    (LOG2N)
    ) u_wr_dly (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_vld   (o_rd_en),
        .i_addr  (o_rd_addr),
        .i_is_b  (o_rd_is_b),
        .o_vld   (o_wr_en),
        .o_addr  (o_wr_addr),
        .o_is_b  (o_wr_is_b),
        .o_empty (pipe_empty)
    );

endmodule

// File: doc/fft_stage_seq.md
Name: fft_stage_seq

Overview:
Sequencer for the in-place radix-2 DIT FFT built on the 512x16 dual-port BRAM. It walks all log2(N) stages and issues one operand read per cycle (A, then B of each butterfly) plus the matching twiddle index. A write-back address pipeline issues the butterfly results, and each stage drains before the next one starts. Input samples are already stored in bit-reversed order by the loader; this block does no reordering.

Parameters:
LOG2N, 9, log2 of FFT size N; address width is LOG2N and twiddle index width is LOG2N-1
WR_DELAY, 6, cycles from an operand read to the write of its result; must be >= 3 (BRAM latency 1 + butterfly latency WR_DELAY-2 >= 1)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  begin an FFT; sampled only in IDLE
o_busy  out  1  high from the cycle after start until done
o_done  out  1  one-cycle pulse after the final write of the final stage
o_stage  out  4  current stage index s, 0..LOG2N-1
o_rd_en  out  1  BRAM read enable (both real and imag banks)
o_rd_addr  out  LOG2N  BRAM read address
o_rd_is_b  out  1  0 = this read is operand A, 1 = operand B
o_tw_idx  out  LOG2N-1  twiddle ROM index, valid on A-read cycles, held on B-read cycles
o_wr_en  out  1  BRAM write enable
o_wr_addr  out  LOG2N  BRAM write address
o_wr_is_b  out  1  0 = write A' result, 1 = write B' result

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, counters 0, write pipeline cleared. Reset mid-FFT aborts with no further writes and no o_done.
- States: IDLE -> READ on i_start. READ -> DRAIN after the B read of butterfly N/2-1. DRAIN -> READ (s+1) or DONE once the write pipeline is empty. DONE -> IDLE after 1 cycle.
- IDLE: o_busy=0. When i_start=1, move to READ with s=0, k=0. The first o_rd_en occurs 1 cycle after i_start is sampled.
- READ: butterfly counter k runs 0..N/2-1. Each butterfly takes 2 cycles, phase 0 = A and phase 1 = B.
  - half = 1<<s; addrA = ((k>>s)<<(s+1)) | (k & (half-1)); addrB = addrA + half.
  - tw = (k & (half-1)) << (LOG2N-1-s).
  - o_rd_en=1 on every READ cycle, so a stage takes exactly N read cycles.
- Write pipeline: a read of address X with is_b=b in cycle t produces o_wr_en=1, o_wr_addr=X, o_wr_is_b=b in cycle t+WR_DELAY.
  - Implemented as a WR_DELAY-deep shift register of {valid, addr, is_b}.
  - Writes of one stage are address-disjoint from its reads, so there is no hazard within a stage.
- DRAIN: o_rd_en=0. Wait until the pipeline holds no valid entries, i.e. WR_DELAY cycles after the last read. On the cycle the last write is issued, the next state is READ with s+1 and k=0, or DONE if s=LOG2N-1. This guarantees every write of stage s lands before any read of stage s+1.
- DONE: o_done=1 for 1 cycle, o_busy=0 in that cycle, and o_stage holds LOG2N-1.
- o_busy is 1 in READ and DRAIN only.
- Total time from i_start sampled to o_done is LOG2N*(N+WR_DELAY)+1 cycles, which is 4663 at the defaults.
- i_start while busy is ignored; it is not queued. i_start held high in DONE is ignored; it is re-sampled in IDLE on the next cycle.
- Counter widths: k has LOG2N-1 bits and wraps to 0 at stage end. s saturates at LOG2N-1. No arithmetic overflows the address width.

Decomposition:
- Shared package fft_pkg:
  - constants FFT_LOG2N, FFT_N, FFT_WR_DELAY.
  - typedef addr_t (logic [LOG2N-1:0]).
  - typedef tw_idx_t.
  - enum seq_state_t {IDLE, READ, DRAIN, DONE}.
- One natural sub-module: fft_wr_delay_line, a parameterised WR_DELAY-stage shift register of {valid, addr, is_b}. It has an async clear and exposes an o_empty flag used by DRAIN.

Test Plan:
- Reset mid-READ (stage 3, k=40), with i_rst pulsed high between clock edges -> all outputs 0 immediately; no o_wr_en or o_done afterwards; a fresh i_start then gives the first read at addr 0.
- Stage 0 addresses: start from IDLE -> reads 0,1,2,3,... with is_b alternating 0,1; tw_idx=0 throughout; o_wr_addr 0 appears exactly 6 cycles after read 0.
- Stage 8 (half=256) -> butterfly k=5 reads A=5, B=261 with tw_idx=5; last butterfly reads A=255, B=511, tw=255.
- Drain and stage hazard: scoreboard every stage -> each address is written exactly once per stage; no read of stage s+1 occurs before the last write of stage s; the gap between the last read and the next first read is WR_DELAY+1 cycles.
- Full run with a BRAM and butterfly model, input impulse at index 0 (bit-reversed loaded) -> all 512 outputs equal; o_done pulses once at cycle 4663; o_busy falls in the same cycle.
- i_start held high for 10 cycles and re-asserted during DRAIN -> only one FFT runs; a second start issued after o_done begins a new run 1 cycle later.
